// File: rtl/bs_pkg.sv
// Shared backscatter definitions: frame size, FSM state encoding and character mapping.
package bs_pkg;

    localparam int unsigned FRAME_BITS = 12;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } bs_state_e;

    // Letter index of an ASCII byte: a-z and A-Z map to 0..25, anything else to 0.
    function automatic logic [4:0] alpha5(input logic [7:0] c);
        logic [4:0] a;
        a = 5'd0;
        if (c >= 8'h61 && c <= 8'h7a) begin
            a = 5'(c - 8'h61);
        end else if (c >= 8'h41 && c <= 8'h5a) begin
            a = 5'(c - 8'h41);
        end
        return a;
    endfunction

    // Frame layout, sent MSB first: six zero bits, a one marker, then the letter index.
    function automatic logic [FRAME_BITS-1:0] bs_frame(input logic [7:0] c);
        return {6'b000000, 1'b1, alpha5(c)};
    endfunction

endpackage

// File: rtl/bs_frame_scheduler_if.sv
// Two-requester character handshake between producers and the frame scheduler.
interface bs_frame_scheduler_if;

    logic       req0_valid;
    logic [7:0] req0_char;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_char;
    logic       req1_ready;

    modport master (
        output req0_valid,
        output req0_char,
        input  req0_ready,
        output req1_valid,
        output req1_char,
        input  req1_ready
    );

    modport slave (
        input  req0_valid,
        input  req0_char,
        output req0_ready,
        input  req1_valid,
        input  req1_char,
        output req1_ready
    );

endinterface

// File: rtl/bs_bit_timer.sv
// Bit-period timer: pulses tick on the last cycle of every T-cycle period while run is high.
module bs_bit_timer #(
    parameter int unsigned T = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int unsigned CntW = (T > 1) ? $clog2(T) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(T - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count while running and wrap at T-1; held at zero while stopped.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bs_frame_scheduler.sv
// Round-robin scheduler serialising characters from two requesters into 12-bit frames.
module bs_frame_scheduler
    import bs_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 20000000,
    parameter int unsigned BIT_HZ   = 1,
    parameter int unsigned GAP_BITS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    bs_frame_scheduler_if.slave  req,
    output logic                 bit_out,
    output logic                 busy,
    output logic                 frame_start,
    output logic                 grant_id
);

    localparam int unsigned T         = CLK_FREQ / BIT_HZ;
    localparam int unsigned GapCycles = GAP_BITS * T;
    localparam int unsigned GapW      = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

    bs_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                  bit_out_q, bit_out_d;
    logic                  frame_start_q, frame_start_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  ready0, ready1;
    logic                  tick;

    bs_bit_timer #(
        .T (T)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q == StSend),
        .tick (tick)
    );

    // Round-robin accept strobes: a lone requester always wins, a tie goes away from last_grant.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!rst && enable && state_q == StIdle) begin
            ready0 = req.req0_valid && (!req.req1_valid || last_grant_q);
            ready1 = req.req1_valid && (!req.req0_valid || !last_grant_q);
        end
    end

    assign req.req0_ready = ready0;
    assign req.req1_ready = ready1;

    // Next-state logic for the IDLE / SEND / GAP sequencer and its datapath.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        bit_idx_d     = bit_idx_q;
        gap_cnt_d     = gap_cnt_q;
        bit_out_d     = bit_out_q;
        frame_start_d = 1'b0;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        unique case (state_q)
            StIdle: begin
                bit_out_d = 1'b0;
                if (ready0 || ready1) begin
                    frame_d       = bs_frame(ready1 ? req.req1_char : req.req0_char);
                    bit_out_d     = frame_d[FRAME_BITS-1];
                    bit_idx_d     = 4'd0;
                    grant_d       = ready1;
                    last_grant_d  = ready1;
                    frame_start_d = 1'b1;
                    state_d       = StSend;
                end
            end
            StSend: begin
                if (tick) begin
                    if (bit_idx_q == 4'(FRAME_BITS - 1)) begin
                        bit_out_d = 1'b0;
                        bit_idx_d = 4'd0;
                        gap_cnt_d = '0;
                        state_d   = (GAP_BITS > 0) ? StGap : StIdle;
                    end else begin
                        // frame_q is shifted so the bit in flight always sits at the MSB.
                        bit_idx_d = bit_idx_q + 4'd1;
                        bit_out_d = frame_q[FRAME_BITS-2];
                        frame_d   = frame_q << 1;
                    end
                end
            end
            StGap: begin
                bit_out_d = 1'b0;
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            frame_q       <= '0;
            bit_idx_q     <= 4'd0;
            gap_cnt_q     <= '0;
            bit_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            bit_idx_q     <= bit_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            bit_out_q     <= bit_out_d;
            frame_start_q <= frame_start_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign bit_out     = bit_out_q;
    assign busy        = (state_q != StIdle);
    assign frame_start = frame_start_q;
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_bs_frame_scheduler.sv
// Bench for bs_frame_scheduler: two instances (no gap, two-bit gap) checked against a frame model.
module tb_bs_frame_scheduler;

    localparam int T    = 4;
    localparam int FB   = 12;
    localparam int PER  = FB * T + 1;
    localparam int PERG = (FB + 2) * T + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic bit_out_a, busy_a, fs_a, gid_a;
    logic bit_out_g, busy_g, fs_g, gid_g;

    int n_checks = 0;
    int n_fail = 0;
    int m_last_a = 1;
    int m_last_g = 1;

    logic cb_a [256];
    logic cy_a [256];
    logic cf_a [256];
    logic cg_a [256];
    logic cb_g [256];
    logic cy_g [256];
    logic cf_g [256];
    logic cg_g [256];
    logic c0_g [256];
    logic c1_g [256];
    logic c0_a [256];
    logic c1_a [256];

    bs_frame_scheduler_if ifa ();
    bs_frame_scheduler_if ifg ();

    bs_frame_scheduler #(
        .CLK_FREQ (4),
        .BIT_HZ   (1),
        .GAP_BITS (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (ifa),
        .bit_out     (bit_out_a),
        .busy        (busy_a),
        .frame_start (fs_a),
        .grant_id    (gid_a)
    );

    bs_frame_scheduler #(
        .CLK_FREQ (4),
        .BIT_HZ   (1),
        .GAP_BITS (2)
    ) dut_gap (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (ifg),
        .bit_out     (bit_out_g),
        .busy        (busy_g),
        .frame_start (fs_g),
        .grant_id    (gid_g)
    );

    always #5 clk = ~clk;

    // Letter index straight from the character classes.
    function automatic int m_alpha(input int c);
        if (c >= 97 && c <= 122) return c - 97;
        if (c >= 65 && c <= 90) return c - 65;
        return 0;
    endfunction

    // Expected bit_out j cycles after the accept edge (bit j/T of 0b000000_1_aaaaa).
    function automatic logic m_bit(input int c, input int j);
        int word;
        word = 32 + m_alpha(c);
        if (j < 0 || j >= FB * T) return 1'b0;
        return ((word >> (FB - 1 - j / T)) & 1) != 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            cb_a[i] = bit_out_a; cy_a[i] = busy_a; cf_a[i] = fs_a; cg_a[i] = gid_a;
            c0_a[i] = ifa.req0_ready; c1_a[i] = ifa.req1_ready;
            cb_g[i] = bit_out_g; cy_g[i] = busy_g; cf_g[i] = fs_g; cg_g[i] = gid_g;
            c0_g[i] = ifg.req0_ready; c1_g[i] = ifg.req1_ready;
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1; ifa.req0_char = 8'h61; ifa.req1_char = 8'h62;
        ifg.req0_valid = 1'b1; ifg.req1_valid = 1'b1; ifg.req0_char = 8'h61; ifg.req1_char = 8'h62;
        step();
        step();
        n_checks++; if (bit_out_a !== 1'b0) begin n_fail++; $display("FAIL reset_bit_out got %b want 0", bit_out_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_checks++; if (fs_a !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b want 0", fs_a); end
        n_checks++; if (gid_a !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id got %b want 0", gid_a); end
        n_checks++; if (ifa.req0_ready !== 1'b0 || ifa.req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b%b want 00", ifa.req0_ready, ifa.req1_ready); end
        n_checks++; if (busy_g !== 1'b0 || bit_out_g !== 1'b0) begin
            n_fail++; $display("FAIL reset_gap_dut got busy %b bit %b want 0 0", busy_g, bit_out_g); end
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
        ifg.req0_valid = 1'b0; ifg.req1_valid = 1'b0;
        rst = 1'b0;
        m_last_a = 1; m_last_g = 1;
        step();
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy_a); end
    endtask

    task automatic test_single();
        int ch;
        ch = "h";
        ifa.req0_char = 8'(ch); ifa.req0_valid = 1'b1;
        #1;
        n_checks++; if (ifa.req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", ifa.req0_ready); end
        step();
        ifa.req0_valid = 1'b0; m_last_a = 0;
        capture(52);
        for (int j = 0; j < 52; j++) begin
            n_checks++; if (cb_a[j] !== m_bit(ch, j)) begin n_fail++; $display("FAIL single_bit j=%0d got %b want %b", j, cb_a[j], m_bit(ch, j)); end
            n_checks++; if (cy_a[j] !== (j < FB * T)) begin n_fail++; $display("FAIL single_busy j=%0d got %b want %b", j, cy_a[j], j < FB * T); end
            n_checks++; if (cf_a[j] !== (j == 0)) begin n_fail++; $display("FAIL single_fs j=%0d got %b want %b", j, cf_a[j], j == 0); end
            n_checks++; if (cg_a[j] !== 1'b0) begin n_fail++; $display("FAIL single_gid j=%0d got %b want 0", j, cg_a[j]); end
        end
    endtask

    task automatic test_round_robin();
        int last, g, ch, s;
        rst = 1'b1; step(); rst = 1'b0; m_last_a = 1;
        ifa.req0_char = "a"; ifa.req1_char = "B";
        ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1;
        #1;
        capture(4 * PER + 1);
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
        last = m_last_a;
        for (int k = 0; k <= 4; k++) begin
            s = k * PER;
            n_checks++; if (c0_a[s] !== (last == 1) || c1_a[s] !== (last == 0) || cy_a[s] !== 1'b0) begin
                n_fail++; $display("FAIL rr_idle k=%0d got rdy %b%b busy %b want %b%b 0", k, c0_a[s], c1_a[s], cy_a[s], last == 1, last == 0); end
            if (k < 4) begin
                g = 1 - last;
                last = g;
                ch = (g == 0) ? 97 : 66;
                for (int j = 0; j < FB * T; j++) begin
                    s = k * PER + 1 + j;
                    n_checks++; if (cb_a[s] !== m_bit(ch, j)) begin n_fail++; $display("FAIL rr_bit k=%0d j=%0d got %b want %b", k, j, cb_a[s], m_bit(ch, j)); end
                    n_checks++; if (cg_a[s] !== 1'(g)) begin n_fail++; $display("FAIL rr_gid k=%0d j=%0d got %b want %0d", k, j, cg_a[s], g); end
                    n_checks++; if (cf_a[s] !== (j == 0)) begin n_fail++; $display("FAIL rr_fs k=%0d j=%0d got %b want %b", k, j, cf_a[s], j == 0); end
                    n_checks++; if (c0_a[s] !== 1'b0 || c1_a[s] !== 1'b0) begin n_fail++; $display("FAIL rr_ready_busy k=%0d j=%0d got %b%b want 00", k, j, c0_a[s], c1_a[s]); end
                end
            end
        end
        m_last_a = last;
    endtask

    task automatic test_alpha();
        int chars [8];
        chars = '{90, 122, 51, 64, 123, 0, 0, 0};
        for (int i = 5; i < 8; i++) chars[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            ifa.req1_char = 8'(chars[i]); ifa.req1_valid = 1'b1;
            #1;
            n_checks++; if (ifa.req1_ready !== 1'b1 || ifa.req0_ready !== 1'b0) begin
                n_fail++; $display("FAIL alpha_ready c=%0d got %b%b want 01", chars[i], ifa.req0_ready, ifa.req1_ready); end
            step();
            ifa.req1_valid = 1'b0; m_last_a = 1;
            capture(PER);
            for (int j = 0; j < PER; j++) begin
                n_checks++; if (cb_a[j] !== m_bit(chars[i], j)) begin
                    n_fail++; $display("FAIL alpha_bit c=%0d j=%0d got %b want %b", chars[i], j, cb_a[j], m_bit(chars[i], j)); end
                n_checks++; if (cy_a[j] !== (j < FB * T)) begin
                    n_fail++; $display("FAIL alpha_busy c=%0d j=%0d got %b want %b", chars[i], j, cy_a[j], j < FB * T); end
            end
            n_checks++; if (cg_a[0] !== 1'b1) begin n_fail++; $display("FAIL alpha_gid c=%0d got %b want 1", chars[i], cg_a[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int ch;
        ifa.req0_char = "m"; ifa.req0_valid = 1'b1;
        #1;
        n_checks++; if (ifa.req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", ifa.req0_ready); end
        step();
        ifa.req0_valid = 1'b0; m_last_a = 0;
        // Last cycle of bit 5: without reset the next edge would shift in the marker bit.
        for (int i = 0; i < 23; i++) step();
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", busy_a); end
        rst = 1'b1;
        ifa.req0_char = "q"; ifa.req1_char = "r"; ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1;
        #1;
        n_checks++; if (ifa.req0_ready !== 1'b0 || ifa.req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ready_in_rst got %b%b want 00", ifa.req0_ready, ifa.req1_ready); end
        step();
        n_checks++; if (bit_out_a !== 1'b0) begin n_fail++; $display("FAIL rmid_bit_out got %b want 0", bit_out_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy_a); end
        n_checks++; if (fs_a !== 1'b0) begin n_fail++; $display("FAIL rmid_fs got %b want 0", fs_a); end
        rst = 1'b0; m_last_a = 1;
        #1;
        n_checks++; if (ifa.req0_ready !== 1'b1 || ifa.req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_first_grant got %b%b want 10", ifa.req0_ready, ifa.req1_ready); end
        step();
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0; m_last_a = 0;
        ch = "q";
        capture(PER);
        for (int j = 0; j < PER; j++) begin
            n_checks++; if (cb_a[j] !== m_bit(ch, j) || cf_a[j] !== (j == 0) || cg_a[j] !== 1'b0) begin
                n_fail++; $display("FAIL rmid_frame j=%0d got bit %b fs %b gid %b want %b %b 0", j, cb_a[j], cf_a[j], cg_a[j], m_bit(ch, j), j == 0); end
        end
    endtask

    task automatic test_enable();
        int ch, ch2;
        ch = "e"; ch2 = "k";
        ifa.req0_char = 8'(ch); ifa.req0_valid = 1'b1;
        #1;
        n_checks++; if (ifa.req0_ready !== 1'b1) begin n_fail++; $display("FAIL en_ready got %b want 1", ifa.req0_ready); end
        step();
        ifa.req0_valid = 1'b0; m_last_a = 0;
        for (int j = 0; j < 60; j++) begin
            if (j > 0) step();
            n_checks++; if (bit_out_a !== m_bit(ch, j)) begin n_fail++; $display("FAIL en_bit j=%0d got %b want %b", j, bit_out_a, m_bit(ch, j)); end
            n_checks++; if (busy_a !== (j < FB * T)) begin n_fail++; $display("FAIL en_busy j=%0d got %b want %b", j, busy_a, j < FB * T); end
            if (j > 0) begin
                n_checks++; if (ifa.req0_ready !== 1'b0 || ifa.req1_ready !== 1'b0) begin
                    n_fail++; $display("FAIL en_no_ready j=%0d got %b%b want 00", j, ifa.req0_ready, ifa.req1_ready); end
            end
            if (j == 10) begin
                enable = 1'b0;
                ifa.req1_char = 8'(ch2); ifa.req1_valid = 1'b1;
            end
        end
        enable = 1'b1;
        #1;
        n_checks++; if (ifa.req1_ready !== 1'b1 || ifa.req0_ready !== 1'b0) begin
            n_fail++; $display("FAIL en_resume_ready got %b%b want 01", ifa.req0_ready, ifa.req1_ready); end
        step();
        ifa.req1_valid = 1'b0; m_last_a = 1;
        capture(PER);
        for (int j = 0; j < PER; j++) begin
            n_checks++; if (cb_a[j] !== m_bit(ch2, j) || cf_a[j] !== (j == 0) || cg_a[j] !== 1'b1) begin
                n_fail++; $display("FAIL en_frame j=%0d got bit %b fs %b gid %b want %b %b 1", j, cb_a[j], cf_a[j], cg_a[j], m_bit(ch2, j), j == 0); end
        end
    endtask

    task automatic test_gap();
        int last, g, ch, s;
        ifg.req0_char = "c"; ifg.req1_char = "d";
        ifg.req0_valid = 1'b1; ifg.req1_valid = 1'b1;
        #1;
        capture(2 * PERG + 1);
        ifg.req0_valid = 1'b0; ifg.req1_valid = 1'b0;
        last = m_last_g;
        for (int k = 0; k <= 2; k++) begin
            s = k * PERG;
            n_checks++; if (c0_g[s] !== (last == 1) || c1_g[s] !== (last == 0) || cy_g[s] !== 1'b0) begin
                n_fail++; $display("FAIL gap_idle k=%0d got rdy %b%b busy %b want %b%b 0", k, c0_g[s], c1_g[s], cy_g[s], last == 1, last == 0); end
            if (k < 2) begin
                g = 1 - last;
                last = g;
                ch = (g == 0) ? 99 : 100;
                for (int j = 0; j < PERG - 1; j++) begin
                    s = k * PERG + 1 + j;
                    n_checks++; if (cb_g[s] !== m_bit(ch, j)) begin n_fail++; $display("FAIL gap_bit k=%0d j=%0d got %b want %b", k, j, cb_g[s], m_bit(ch, j)); end
                    n_checks++; if (cy_g[s] !== 1'b1) begin n_fail++; $display("FAIL gap_busy k=%0d j=%0d got %b want 1", k, j, cy_g[s]); end
                    n_checks++; if (cf_g[s] !== (j == 0) || cg_g[s] !== 1'(g)) begin
                        n_fail++; $display("FAIL gap_fs_gid k=%0d j=%0d got %b %b want %b %0d", k, j, cf_g[s], cg_g[s], j == 0, g); end
                end
            end
        end
        m_last_g = last;
    endtask

    initial begin
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0; ifa.req0_char = 8'h0; ifa.req1_char = 8'h0;
        ifg.req0_valid = 1'b0; ifg.req1_valid = 1'b0; ifg.req0_char = 8'h0; ifg.req1_char = 8'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_alpha();
        test_reset_mid();
        test_enable();
        test_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bs_frame_scheduler.md
BS_FRAME_SCHEDULER -- requirements
Module: bs_frame_scheduler

Interface
REQ-001 Parameter CLK_FREQ, default 20000000: input clock frequency in Hz.
REQ-002 Parameter BIT_HZ, default 1: bit rate in Hz; T = CLK_FREQ/BIT_HZ clock cycles per bit, T >= 2.
REQ-003 Parameter GAP_BITS, default 0: number of idle bit periods inserted after each frame.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  when low, no new frame is accepted; a frame already in flight completes.
REQ-007 req0_valid / req1_valid  input  1 each  requester has a character pending.
REQ-008 req0_char / req1_char  input  8 each  ASCII character; must be held stable while valid is high.
REQ-009 req0_ready / req1_ready  output  1 each  combinational accept strobe; a transfer occurs on a clock edge where valid and ready are both high.
REQ-010 bit_out  output  1  registered serial frame bit, MSB first.
REQ-011 busy  output  1  high in every state other than IDLE.
REQ-012 frame_start  output  1  one-cycle pulse in the first cycle of each frame.
REQ-013 grant_id  output  1  index of the requester whose frame is in flight; held until the next accept.

Function
REQ-014 Frame encoding: 12 bits, {6'b000000, 1'b1, alpha5}; alpha5 = c-"a" for a-z, c-"A" for A-Z, 0 for any other byte.
REQ-015 FSM states: IDLE, SEND, GAP.
REQ-016 IDLE: bit_out = 0; at most one ready is high, and only when enable = 1 and that requester's valid = 1.
REQ-017 Arbitration is round-robin.
- Pointer last_grant starts at 1 after reset, so req0 wins first.
- When both are valid, ready goes to the requester other than last_grant.
- When one is valid, that requester gets ready regardless of the pointer.
- The pointer updates only on an accept.
REQ-018 Accept edge (IDLE with a handshake):
- load the frame;
- set grant_id;
- bit_out <= frame[11];
- clear bit_idx and tick_cnt;
- state <= SEND.
frame_start is high for exactly the cycle following the accept edge.
REQ-019 SEND: each bit is held exactly T cycles; bit_idx increments 0..11 when tick_cnt == T-1, and bit_out then takes the next bit.
REQ-020 SEND exit: after bit 11 completes its T cycles, go to GAP if GAP_BITS > 0 (bit_out = 0), else to IDLE (bit_out = 0).
REQ-021 GAP: bit_out = 0 for GAP_BITS*T cycles, then IDLE.
REQ-022 Throughput: the frame occupies 12*T cycles from the accept edge; IDLE lasts at least one cycle between frames, so the back-to-back frame period is (12+GAP_BITS)*T+1 cycles.
REQ-023 No ready is asserted outside IDLE; valid held during SEND/GAP waits and never drops a character.
REQ-024 Deasserting enable mid-frame does not truncate the frame; the block stays in IDLE until enable returns high.
REQ-025 Counter widths: tick_cnt is clog2(T) bits wrapping at T-1; bit_idx is 4 bits; the GAP counter is sized for GAP_BITS*T.

Reset
REQ-026 While rst is high at an edge:
- state = IDLE;
- bit_out = 0, busy = 0, frame_start = 0, grant_id = 0;
- last_grant = 1;
- all counters = 0.
REQ-027 Reset mid-frame aborts the frame: bit_out is 0 from the cycle after the reset edge, and the partial character is discarded without re-request.
REQ-028 No ready is asserted while rst is high.

Structure
REQ-029 Shared package bs_pkg holds FRAME_BITS = 12, the FSM state encoding, and the alpha5 function, for reuse by other backscatter blocks.
REQ-030 One sub-module, bs_bit_timer (parameter T; inputs clk, rst, run; output tick), generates tick when its counter reaches T-1 and clears while run = 0.

Verification
All scenarios use CLK_FREQ=4, BIT_HZ=1 (T=4) unless stated.
REQ-031 Single "h" on req0 -> frame_start one cycle after accept; bit_out = 0,0,0,0,0,0,1,0,0,1,1,1, each held 4 cycles; busy for 48 cycles.
REQ-032 Both requesters valid continuously, req0 "a", req1 "B" -> grants alternate 0,1,0,1; frame_start pulses 49 cycles apart; payload bits 00000 then 00001.
REQ-033 Characters "Z", "z", "3" -> alpha5 = 25, 25, 0 (frame tails 1_11001, 1_11001, 1_00000).
REQ-034 GAP_BITS = 2 -> 8 cycles of bit_out = 0 after bit 11, then IDLE; next frame_start 57 cycles after the previous one.
REQ-035 rst pulsed during bit 5 -> bit_out = 0 and busy = 0 on the next cycle; after release with req1 valid, req0 valid first wins the first grant.
REQ-036 enable dropped during SEND -> frame completes all 12 bits; no ready while enable = 0; accept occurs one cycle after enable returns high.
